// File: rtl/msg_key_assembler_if.sv
// Pin-side bus of the message/key assembler.
// master: drives the byte pins and control and observes the buffers (pin driver or bench).
// slave : the assembler itself.
// Inputs : iData, iStrobe, iSel, iClear, iEncrypt_done
// Outputs: oMessage, oKey, oMessage_counter, oKey_assemble_counter,
//          oCan_encrypt, oOverflow, oBusy
interface msg_key_assembler_if #(
  parameter int unsigned MSG_SIZE = 512,
  parameter int unsigned CNT_W    = $clog2(MSG_SIZE) + 1
);
  logic [7:0]          iData;
  logic                iStrobe;
  logic                iSel;
  logic                iClear;
  logic                iEncrypt_done;
  logic [MSG_SIZE-1:0] oMessage;
  logic [MSG_SIZE-1:0] oKey;
  logic [CNT_W-1:0]    oMessage_counter;
  logic [CNT_W-1:0]    oKey_assemble_counter;
  logic                oCan_encrypt;
  logic                oOverflow;
  logic                oBusy;

  modport master (
    output iData, iStrobe, iSel, iClear, iEncrypt_done,
    input  oMessage, oKey, oMessage_counter, oKey_assemble_counter,
           oCan_encrypt, oOverflow, oBusy
  );

  modport slave (
    input  iData, iStrobe, iSel, iClear, iEncrypt_done,
    output oMessage, oKey, oMessage_counter, oKey_assemble_counter,
           oCan_encrypt, oOverflow, oBusy
  );
endinterface

// File: rtl/msg_key_assembler.sv
// Upstream stage of the XOR cipher datapath. Shifts message and key bytes from
// the 8-bit pin bus into two MSG_SIZE-bit buffers. The byte strobe is an async
// pin; it is synchronised and edge-detected so each pulse loads exactly one byte.
// Ports: iClk, iRst (async, active-low), bus (slave modport of msg_key_assembler_if).
module msg_key_assembler #(
  parameter int unsigned MSG_SIZE = 512,
  parameter int unsigned CNT_W    = $clog2(MSG_SIZE) + 1
) (
  input logic                 iClk,
  input logic                 iRst,
  msg_key_assembler_if.slave  bus
);

  localparam logic [0:0] LOAD  = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(MSG_SIZE);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(8);

  logic [0:0]          state;
  logic [0:0]          stateNext;
  logic                s1, s2, s3, wr;
  logic [MSG_SIZE-1:0] msgNext, keyNext;
  logic [CNT_W-1:0]    msgCntNext, keyCntNext;
  logic                ovfNext;
  logic [MSG_SIZE+7:0] msgShift, keyShift;

  // The encrypt stage owns completion; the flag is observed here only.
  logic unusedEncryptDone;
  assign unusedEncryptDone = bus.iEncrypt_done;

  // Strobe synchroniser and rising-edge pulse; these flops ignore iClear on purpose.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      wr <= 1'b0;
    end else begin
      s1 <= bus.iStrobe;
      s2 <= s1;
      s3 <= s2;
      wr <= s2 & ~s3;
    end
  end

  // Shift-in views; the concatenation keeps MSG_SIZE == 8 legal.
  assign msgShift = {bus.oMessage, bus.iData};
  assign keyShift = {bus.oKey, bus.iData};

  // Next buffer/counter/overflow values; clear wins over a coincident write.
  always_comb begin
    msgNext    = bus.oMessage;
    keyNext    = bus.oKey;
    msgCntNext = bus.oMessage_counter;
    keyCntNext = bus.oKey_assemble_counter;
    ovfNext    = bus.oOverflow;
    if (bus.iClear) begin
      msgNext    = '0;
      keyNext    = '0;
      msgCntNext = '0;
      keyCntNext = '0;
      ovfNext    = 1'b0;
    end else if (wr) begin
      if (!bus.iSel) begin
        if (bus.oMessage_counter < FULL) begin
          msgNext    = msgShift[MSG_SIZE-1:0];
          msgCntNext = bus.oMessage_counter + STEP;
        end else begin
          ovfNext = 1'b1;
        end
      end else begin
        if (bus.oKey_assemble_counter < FULL) begin
          keyNext    = keyShift[MSG_SIZE-1:0];
          keyCntNext = bus.oKey_assemble_counter + STEP;
        end else begin
          ovfNext = 1'b1;
        end
      end
    end
  end

  // FSM next state; READY is entered on the edge that makes both counters full.
  always_comb begin
    stateNext = state;
    case (state)
      LOAD:    if (!bus.iClear && msgCntNext == FULL && keyCntNext == FULL) stateNext = READY;
      READY:   if (bus.iClear) stateNext = LOAD;
      default: stateNext = LOAD;
    endcase
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= LOAD;
    else       state <= stateNext;
  end

  // Registered outputs; qualifiers follow the registered state one cycle later.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      bus.oMessage              <= '0;
      bus.oKey                  <= '0;
      bus.oMessage_counter      <= '0;
      bus.oKey_assemble_counter <= '0;
      bus.oOverflow             <= 1'b0;
      bus.oCan_encrypt          <= 1'b0;
      bus.oBusy                 <= 1'b0;
    end else begin
      bus.oMessage              <= msgNext;
      bus.oKey                  <= keyNext;
      bus.oMessage_counter      <= msgCntNext;
      bus.oKey_assemble_counter <= keyCntNext;
      bus.oOverflow             <= ovfNext;
      bus.oCan_encrypt          <= !bus.iClear && (state == READY);
      bus.oBusy                 <= !bus.iClear && (state == LOAD) &&
                                   (bus.oMessage_counter != '0 || bus.oKey_assemble_counter != '0);
    end
  end

endmodule

// File: tb/tb_msg_key_assembler.sv
// Self-checking bench for msg_key_assembler: directed byte loads, a reference
// model of the buffers, and a queue-based monitor that compares DUT outputs.
module tb_msg_key_assembler;
  localparam int unsigned MSG_SIZE = 512;
  localparam int unsigned CNT_W    = 10;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  msg_key_assembler_if #(.MSG_SIZE(MSG_SIZE), .CNT_W(CNT_W)) bus ();

  msg_key_assembler #(.MSG_SIZE(MSG_SIZE), .CNT_W(CNT_W)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [MSG_SIZE-1:0] msg;
    logic [MSG_SIZE-1:0] key;
    logic [CNT_W-1:0]    mc;
    logic [CNT_W-1:0]    kc;
    logic                can;
    logic                ovf;
    logic                busy;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];

  int nChecks = 0;
  int nFails  = 0;

  // Reference model
  logic [MSG_SIZE-1:0] mMsg, mKey;
  int                  mMc, mKc;
  logic                mOvf, mReady;

  task automatic chk(input string nm, input logic [MSG_SIZE-1:0] act, input logic [MSG_SIZE-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic modelClear();
    mMsg = '0; mKey = '0; mMc = 0; mKc = 0; mOvf = 1'b0; mReady = 1'b0;
  endtask

  task automatic modelWrite(input logic sel, input logic [7:0] d);
    if (!sel) begin
      if (mMc < MSG_SIZE) begin mMsg = {mMsg[MSG_SIZE-9:0], d}; mMc += 8; end
      else mOvf = 1'b1;
    end else begin
      if (mKc < MSG_SIZE) begin mKey = {mKey[MSG_SIZE-9:0], d}; mKc += 8; end
      else mOvf = 1'b1;
    end
    if (mMc == MSG_SIZE && mKc == MSG_SIZE) mReady = 1'b1;
  endtask

  // Queue the model snapshot; the monitor compares it on the next falling edge.
  task automatic expectNow(input string nm);
    exp_t e;
    #1;
    e.msg  = mMsg;
    e.key  = mKey;
    e.mc   = CNT_W'(mMc);
    e.kc   = CNT_W'(mKc);
    e.can  = mReady;
    e.ovf  = mOvf;
    e.busy = !mReady && (mMc != 0 || mKc != 0);
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(negedge iClk);
    @(negedge iClk);
  endtask

  // Monitor: pops every pending expectation and compares against the DUT.
  always @(negedge iClk) begin
    while (expQ.size() > 0) begin
      exp_t  e;
      string nm;
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      chk({nm, ".msg"},  bus.oMessage, e.msg);
      chk({nm, ".key"},  bus.oKey, e.key);
      chk({nm, ".mcnt"}, MSG_SIZE'(bus.oMessage_counter), MSG_SIZE'(e.mc));
      chk({nm, ".kcnt"}, MSG_SIZE'(bus.oKey_assemble_counter), MSG_SIZE'(e.kc));
      chk({nm, ".can"},  MSG_SIZE'(bus.oCan_encrypt), MSG_SIZE'(e.can));
      chk({nm, ".ovf"},  MSG_SIZE'(bus.oOverflow), MSG_SIZE'(e.ovf));
      chk({nm, ".busy"}, MSG_SIZE'(bus.oBusy), MSG_SIZE'(e.busy));
    end
  end

  task automatic sendByte(input logic sel, input logic [7:0] d);
    @(negedge iClk);
    bus.iData   = d;
    bus.iSel    = sel;
    bus.iStrobe = 1'b1;
    repeat (2) @(negedge iClk);
    bus.iStrobe = 1'b0;
    repeat (6) @(negedge iClk);
    modelWrite(sel, d);
  endtask

  task automatic pulseClear();
    @(negedge iClk);
    bus.iClear = 1'b1;
    @(negedge iClk);
    bus.iClear = 1'b0;
    modelClear();
  endtask

  initial begin
    int                  lat;
    logic [CNT_W-1:0]    c0;
    logic [MSG_SIZE-1:0] tmp;

    iRst              = 1'b0;
    bus.iData         = '0;
    bus.iStrobe       = 1'b0;
    bus.iSel          = 1'b0;
    bus.iClear        = 1'b0;
    bus.iEncrypt_done = 1'b0;
    modelClear();
    repeat (3) @(negedge iClk);
    iRst = 1'b1;
    expectNow("reset");

    // Long strobe: one write, 4-cycle latency
    @(negedge iClk);
    bus.iData   = 8'h5A;
    bus.iSel    = 1'b0;
    bus.iStrobe = 1'b1;
    c0  = bus.oMessage_counter;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge iClk);
      #1;
      if (lat == 0 && bus.oMessage_counter != c0) lat = n;
    end
    chk("latency", MSG_SIZE'(lat), MSG_SIZE'(4));
    repeat (12) @(negedge iClk);
    bus.iStrobe = 1'b0;
    repeat (6) @(negedge iClk);
    modelWrite(1'b0, 8'h5A);
    expectNow("single_pulse");
    pulseClear();
    expectNow("clear1");

    // Sequential message 00..3F, key all FF
    for (int i = 0; i < 64; i++) sendByte(1'b0, 8'(i));
    expectNow("msg_only");
    for (int i = 0; i < 64; i++) sendByte(1'b1, 8'hFF);
    expectNow("full_seq");
    tmp = bus.oMessage;
    chk("msg_first_byte", MSG_SIZE'(tmp[511:504]), MSG_SIZE'(8'h00));
    chk("msg_last_byte",  MSG_SIZE'(tmp[7:0]),     MSG_SIZE'(8'h3F));
    chk("key_all_ones",   bus.oKey, {MSG_SIZE{1'b1}});
    chk("full_mcnt",      MSG_SIZE'(bus.oMessage_counter), MSG_SIZE'(512));
    chk("full_can",       MSG_SIZE'(bus.oCan_encrypt), MSG_SIZE'(1));
    pulseClear();
    expectNow("clear2");

    // Interleaved bytes
    for (int i = 0; i < 64; i++) begin
      sendByte(1'b0, 8'hC0 ^ 8'(i));
      if (i == 63) expectNow("before_last");
      sendByte(1'b1, 8'(i * 3));
      if (i == 31) expectNow("interleave_mid");
    end
    expectNow("interleave_full");
    tmp = bus.oKey;
    chk("key_first_byte", MSG_SIZE'(tmp[511:504]), MSG_SIZE'(8'h00));
    chk("key_last_byte",  MSG_SIZE'(tmp[7:0]),     MSG_SIZE'(8'hBD));

    // Overflow after full, sticky
    sendByte(1'b0, 8'hAA);
    expectNow("overflow");
    repeat (20) @(negedge iClk);
    expectNow("overflow_sticky");

    // Clear on the same edge as the write
    @(negedge iClk);
    bus.iData   = 8'h77;
    bus.iSel    = 1'b0;
    bus.iStrobe = 1'b1;
    repeat (3) @(negedge iClk);
    bus.iClear = 1'b1;
    @(negedge iClk);
    bus.iClear  = 1'b0;
    bus.iStrobe = 1'b0;
    modelClear();
    repeat (6) @(negedge iClk);
    expectNow("clear_vs_wr");

    // Async reset mid-load
    for (int i = 0; i < 10; i++) sendByte(1'b0, 8'h10 + 8'(i));
    expectNow("ten_bytes");
    @(posedge iClk);
    #3;
    iRst = 1'b0;
    #1;
    chk("rst_msg",  bus.oMessage, '0);
    chk("rst_mcnt", MSG_SIZE'(bus.oMessage_counter), '0);
    chk("rst_busy", MSG_SIZE'(bus.oBusy), '0);
    modelClear();
    repeat (2) @(negedge iClk);
    iRst = 1'b1;
    sendByte(1'b0, 8'h3C);
    expectNow("after_reset");

    repeat (3) @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
